// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WB, REFILL} cache_state_t;

  localparam int WORD_BITS      = 32;
  localparam int DEF_INDEX_BITS = 8;
  localparam int DEF_LINE_WORDS = 4;
  localparam int OFFSET_BITS    = $clog2(DEF_LINE_WORDS);
  localparam int TAG_BITS       = WORD_BITS - 2 - OFFSET_BITS - DEF_INDEX_BITS;

  typedef logic [DEF_LINE_WORDS*WORD_BITS-1:0] line_t;

  // Helpers return full-width values; callers cast to their own field widths.
  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int ob);
    return (a >> 2) & ((32'd1 << ob) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int ob, input int ib);
    return (a >> (2 + ob)) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int ob, input int ib);
    return a >> (2 + ob + ib);
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Line storage: async read, sync write with a single-word port and a full-line port.
module cache_line_ram
  import cache_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int WORDS     = 4,
  parameter int WIDTH     = WORD_BITS
) (
  input  logic                       clk,
  input  logic [ADDR_BITS-1:0]       addr_i,
  output logic [WORDS*WIDTH-1:0]     line_o,
  input  logic                       word_we_i,
  input  logic [$clog2(WORDS)-1:0]   word_sel_i,
  input  logic [WIDTH-1:0]           word_i,
  input  logic                       line_we_i,
  input  logic [WORDS*WIDTH-1:0]     line_i
);

  logic [WORDS*WIDTH-1:0] mem_q [2**ADDR_BITS];

  assign line_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (line_we_i)      mem_q[addr_i] <= line_i;
    else if (word_we_i) mem_q[addr_i][word_sel_i*WIDTH +: WIDTH] <= word_i;
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back / write-allocate data cache with line-granular
// refill and write-back over a req/ack memory handshake.
module dcache
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  input  logic                     write_enable,
  input  logic                     read_enable,
  output logic                     miss,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_ack
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int TAG_W  = 32 - 2 - OFF_W - INDEX_BITS;
  localparam int NLINES = 1 << INDEX_BITS;

  cache_state_t state_q, state_d;
  logic [NLINES-1:0]     valid_q, dirty_q;
  logic [INDEX_BITS-1:0] m_idx_q;
  logic [TAG_W-1:0]      m_tag_q;
  logic [TAG_W-1:0]      tag_mem [NLINES];

  logic [OFF_W-1:0]        req_off;
  logic [INDEX_BITS-1:0]   req_idx, ram_idx;
  logic [TAG_W-1:0]        req_tag, vic_tag;
  logic [32*LINE_WORDS-1:0] line_rd;
  logic active, hit, store_hit, refill_done;

  assign req_off = OFF_W'(addr_offset(addr, OFF_W));
  assign req_idx = INDEX_BITS'(addr_index(addr, OFF_W, INDEX_BITS));
  assign req_tag = TAG_W'(addr_tag(addr, OFF_W, INDEX_BITS));

  // The miss is serviced against the latched index/tag, so the CPU may drop
  // or change its request mid-miss without disturbing the transfer.
  assign ram_idx = (state_q == IDLE) ? req_idx : m_idx_q;
  assign vic_tag = tag_mem[ram_idx];

  assign active      = read_enable | write_enable;
  assign hit         = active & valid_q[req_idx] & (vic_tag == req_tag) & (state_q == IDLE);
  assign miss        = active & ~hit;
  assign store_hit   = hit & write_enable;
  assign refill_done = (state_q == REFILL) & mem_ack;
  assign rdata       = line_rd[req_off*32 +: 32];
  assign mem_wdata   = line_rd;

  cache_line_ram #(.ADDR_BITS(INDEX_BITS), .WORDS(LINE_WORDS), .WIDTH(32)) u_data (
    .clk        (clk),
    .addr_i     (ram_idx),
    .line_o     (line_rd),
    .word_we_i  (store_hit),
    .word_sel_i (req_off),
    .word_i     (wdata),
    .line_we_i  (refill_done),
    .line_i     (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (refill_done) tag_mem[m_idx_q] <= m_tag_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      m_idx_q <= '0;
      m_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && miss) begin
        m_idx_q <= req_idx;
        m_tag_q <= req_tag;
      end
      if (refill_done) begin
        valid_q[m_idx_q] <= 1'b1;
        dirty_q[m_idx_q] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (miss) state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : REFILL;
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {vic_tag, m_idx_q, {(OFF_W+2){1'b0}}};
        if (mem_ack) state_d = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {m_tag_q, m_idx_q, {(OFF_W+2){1'b0}}};
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
